// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, instruction field positions,
// opcode/funct constants and the decoded ID/EX bundle type.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 8;

    // 4-bit ALU control encoding understood by the downstream ALU
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_ROTL = 4'd8,
        ALU_ROTR = 4'd9,
        ALU_NOR  = 4'd12,
        ALU_ERR  = 4'd14,
        ALU_MUL  = 4'd15
    } alu_op_e;

    // Instruction field slice positions
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SH_HI    = 10;
    localparam int SH_LO    = 6;
    localparam int FN_HI    = 5;
    localparam int IMM_HI   = 15;
    // srl/srlv become rotates when these bits are set
    localparam int ROT_BIT  = 21;
    localparam int ROTV_BIT = 6;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // R-type / SPECIAL2 funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MUL  = 6'h02;

    // Decoded bundle carried in the ID/EX register
    typedef struct packed {
        alu_op_e           alu_ctrl;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic              wr_en;
        logic [4:0]        wr_reg;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              branch_ne;
        logic              illegal;
    } alu_bundle_t;

    function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] zero_ext16(input logic [15:0] imm);
        return {{(DATA_W-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of a MIPS instruction plus register-file data into
// an ALU opcode, aligned operands and write-back/memory/branch controls.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output alu_bundle_t       bundle_o
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [DATA_W-1:0] shamt_ext;
    logic [DATA_W-1:0] rs_amt_ext;
    logic        legal;
    alu_bundle_t b;

    assign op         = instr_i[OP_HI:OP_LO];
    assign funct      = instr_i[FN_HI:0];
    assign rt         = instr_i[RT_HI:RT_LO];
    assign rd         = instr_i[RD_HI:RD_LO];
    assign shamt      = instr_i[SH_HI:SH_LO];
    assign imm        = instr_i[IMM_HI:0];
    assign shamt_ext  = {{(DATA_W-5){1'b0}}, shamt};
    assign rs_amt_ext = {{(DATA_W-5){1'b0}}, rs_data_i[4:0]};

    // Upper rs field bits carry no meaning for this decode
    logic unused_rs_bits;
    assign unused_rs_bits = &{1'b0, instr_i[25:22]};

    // Decode: the ALU shifts A by B, so all shifts route rt to A
    always_comb begin
        b          = '0;
        b.alu_ctrl = ALU_ADD;
        b.op_a     = rs_data_i;
        b.op_b     = rt_data_i;
        legal      = 1'b1;
        case (op)
            OP_RTYPE: begin
                b.wr_en  = 1'b1;
                b.wr_reg = rd;
                case (funct)
                    FN_ADD, FN_ADDU: b.alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: b.alu_ctrl = ALU_SUB;
                    FN_AND:          b.alu_ctrl = ALU_AND;
                    FN_OR:           b.alu_ctrl = ALU_OR;
                    FN_XOR:          b.alu_ctrl = ALU_XOR;
                    FN_NOR:          b.alu_ctrl = ALU_NOR;
                    FN_SLT:          b.alu_ctrl = ALU_SLT;
                    FN_SLL: begin
                        b.alu_ctrl = ALU_SLL;
                        b.op_a     = rt_data_i;
                        b.op_b     = shamt_ext;
                    end
                    FN_SRL: begin
                        b.alu_ctrl = instr_i[ROT_BIT] ? ALU_ROTR : ALU_SRL;
                        b.op_a     = rt_data_i;
                        b.op_b     = shamt_ext;
                    end
                    FN_SLLV: begin
                        b.alu_ctrl = ALU_SLL;
                        b.op_a     = rt_data_i;
                        b.op_b     = rs_amt_ext;
                    end
                    FN_SRLV: begin
                        b.alu_ctrl = instr_i[ROTV_BIT] ? ALU_ROTR : ALU_SRL;
                        b.op_a     = rt_data_i;
                        b.op_b     = rs_amt_ext;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_SPECIAL2: begin
                b.alu_ctrl = ALU_MUL;
                b.wr_en    = 1'b1;
                b.wr_reg   = rd;
                legal      = (funct == FN_MUL);
            end
            OP_ADDI, OP_ADDIU: begin
                b.op_b   = sign_ext16(imm);
                b.wr_en  = 1'b1;
                b.wr_reg = rt;
            end
            OP_SLTI: begin
                b.alu_ctrl = ALU_SLT;
                b.op_b     = sign_ext16(imm);
                b.wr_en    = 1'b1;
                b.wr_reg   = rt;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                b.alu_ctrl = (op == OP_ANDI) ? ALU_AND :
                             (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
                b.op_b     = zero_ext16(imm);
                b.wr_en    = 1'b1;
                b.wr_reg   = rt;
            end
            OP_LW: begin
                b.op_b     = sign_ext16(imm);
                b.mem_read = 1'b1;
                b.wr_en    = 1'b1;
                b.wr_reg   = rt;
            end
            OP_SW: begin
                b.op_b      = sign_ext16(imm);
                b.mem_write = 1'b1;
                b.wr_reg    = rt;
            end
            OP_BEQ, OP_BNE: begin
                b.alu_ctrl  = ALU_SUB;
                b.branch    = 1'b1;
                b.branch_ne = (op == OP_BNE);
                b.wr_reg    = rt;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            b          = '0;
            b.alu_ctrl = ALU_ERR;
            b.illegal  = 1'b1;
        end
        // $0 is hardwired; never request a write to it
        if (b.wr_reg == 5'd0) begin
            b.wr_en = 1'b0;
        end
        bundle_o = b;
    end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decodes the instruction, then registers the bundle
// with stall/flush control and a saturating illegal-instruction counter.
//
// Valid semantics: InValid qualifies Instr/RsData/RtData in the cycle it is
// high; there is no ready. A cycle with InValid=1 and neither Stall nor Flush
// is accepted and appears on the outputs with OutValid=1 one cycle later.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    input  logic [31:0]       Instr,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic              Stall,
    input  logic              Flush,
    output logic              OutValid,
    output logic [CTRL_W-1:0] ALUControl,
    output logic [DATA_W-1:0] OperandA,
    output logic [DATA_W-1:0] OperandB,
    output logic              WrEn,
    output logic [4:0]        WrReg,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              Branch,
    output logic              BranchNe,
    output logic              Illegal,
    output logic [CNT_W-1:0]  IllegalCount
);

    alu_bundle_t      dec_bundle;
    alu_bundle_t      bundle_d, bundle_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    alu_op_decode u_decode (
        .instr_i   (Instr),
        .rs_data_i (RsData),
        .rt_data_i (RtData),
        .bundle_o  (dec_bundle)
    );

    // Next ID/EX contents: flush beats stall; invalid input loads a bubble
    always_comb begin
        bundle_d = bundle_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        if (Flush) begin
            bundle_d = '0;
            valid_d  = 1'b0;
        end else if (!Stall) begin
            valid_d  = InValid;
            bundle_d = InValid ? dec_bundle : '0;
            if (InValid && dec_bundle.illegal && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // ID/EX pipeline register and illegal counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bundle_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            bundle_q <= bundle_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign OutValid     = valid_q;
    assign ALUControl   = bundle_q.alu_ctrl;
    assign OperandA     = bundle_q.op_a;
    assign OperandB     = bundle_q.op_b;
    assign WrEn         = bundle_q.wr_en;
    assign WrReg        = bundle_q.wr_reg;
    assign MemRead      = bundle_q.mem_read;
    assign MemWrite     = bundle_q.mem_write;
    assign Branch       = bundle_q.branch;
    assign BranchNe     = bundle_q.branch_ne;
    assign Illegal      = bundle_q.illegal;
    assign IllegalCount = cnt_q;

endmodule
